// File: rtl/unidade_controle_pkg.sv
// State codes shared by the control unit, the debug display decoder and the bench.
// Codes 0x0-0xE are legal; 0xF is never entered and decodes back to inicial.
package unidade_controle_pkg;

    localparam logic [3:0] ST_INICIAL          = 4'h0;
    localparam logic [3:0] ST_PREPARACAO       = 4'h1;
    localparam logic [3:0] ST_INICIA_SEQUENCIA = 4'h2;
    localparam logic [3:0] ST_MOSTRA_LED       = 4'h3;
    localparam logic [3:0] ST_APAGA_LED        = 4'h4;
    localparam logic [3:0] ST_PROXIMO_LED      = 4'h5;
    localparam logic [3:0] ST_INICIA_JOGADAS   = 4'h6;
    localparam logic [3:0] ST_ESPERA_JOGADA    = 4'h7;
    localparam logic [3:0] ST_REGISTRA         = 4'h8;
    localparam logic [3:0] ST_COMPARACAO       = 4'h9;
    localparam logic [3:0] ST_PROXIMA_JOGADA   = 4'hA;
    localparam logic [3:0] ST_PROXIMO_NIVEL    = 4'hB;
    localparam logic [3:0] ST_FIM_ACERTOU      = 4'hC;
    localparam logic [3:0] ST_FIM_ERROU        = 4'hD;
    localparam logic [3:0] ST_FIM_TIMEOUT      = 4'hE;

    typedef enum logic [3:0] {
        INICIAL          = ST_INICIAL,
        PREPARACAO       = ST_PREPARACAO,
        INICIA_SEQUENCIA = ST_INICIA_SEQUENCIA,
        MOSTRA_LED       = ST_MOSTRA_LED,
        APAGA_LED        = ST_APAGA_LED,
        PROXIMO_LED      = ST_PROXIMO_LED,
        INICIA_JOGADAS   = ST_INICIA_JOGADAS,
        ESPERA_JOGADA    = ST_ESPERA_JOGADA,
        REGISTRA         = ST_REGISTRA,
        COMPARACAO       = ST_COMPARACAO,
        PROXIMA_JOGADA   = ST_PROXIMA_JOGADA,
        PROXIMO_NIVEL    = ST_PROXIMO_NIVEL,
        FIM_ACERTOU      = ST_FIM_ACERTOU,
        FIM_ERROU        = ST_FIM_ERROU,
        FIM_TIMEOUT      = ST_FIM_TIMEOUT
    } estado_t;

endpackage

// File: rtl/unidade_controle_prova.sv
// Moore control unit for the memory game datapath: LED playback, move checking, level stepping.
// Latency: outputs decode from state, one cycle after the condition. Optional macro UNIDADE_CONTROLE_TIMEOUT_EN.
module unidade_controle_prova
    import unidade_controle_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       modo_dificil,
    input  logic       sel_memoria,
    input  logic       fez_jogada,
    input  logic       jogada_igual_memoria,
    input  logic       endereco_igual_limite,
    input  logic       ultimo_nivel,
    input  logic       saida_led_igual_nivel,
    input  logic       meio_timer_led,
    input  logic       fim_timer_led,
    input  logic       deu_timeout,
    output logic       zera_contador_nivel,
    output logic       conta_nivel,
    output logic       zera_contador_jogada,
    output logic       conta_jogada,
    output logic       zeraR,
    output logic       registraR,
    output logic       zera_contador_led,
    output logic       contar_led,
    output logic       liga_led,
    output logic       zera_timer_led,
    output logic       conta_timer_led,
    output logic       zera_timeout,
    output logic       conta_timeout,
    output logic       dificuldade,
    output logic       memoria,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t estado;
    estado_t proximo;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado      <= INICIAL;
            dificuldade <= 1'b0;
            memoria     <= 1'b0;
        end else begin
            estado <= proximo;
            // game mode is frozen for the whole game once preparation is left
            if (estado == PREPARACAO) begin
                dificuldade <= modo_dificil;
                memoria     <= sel_memoria;
            end
        end
    end

`ifndef UNIDADE_CONTROLE_TIMEOUT_EN
    logic unused_deu_timeout;
    assign unused_deu_timeout = deu_timeout;
`endif

    always_comb begin
        proximo              = INICIAL;
        zera_contador_nivel  = 1'b0;
        conta_nivel          = 1'b0;
        zera_contador_jogada = 1'b0;
        conta_jogada         = 1'b0;
        zeraR                = 1'b0;
        registraR            = 1'b0;
        zera_contador_led    = 1'b0;
        contar_led           = 1'b0;
        liga_led             = 1'b0;
        zera_timer_led       = 1'b0;
        conta_timer_led      = 1'b0;
        zera_timeout         = 1'b0;
        conta_timeout        = 1'b0;
        pronto               = 1'b0;
        acertou              = 1'b0;
        errou                = 1'b0;
        timeout              = 1'b0;

        case (estado)
            INICIAL: proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO: begin
                zera_contador_nivel  = 1'b1;
                zera_contador_jogada = 1'b1;
                zeraR                = 1'b1;
                zera_timeout         = 1'b1;
                proximo              = INICIA_SEQUENCIA;
            end
            INICIA_SEQUENCIA: begin
                zera_contador_led = 1'b1;
                zera_timer_led    = 1'b1;
                proximo           = MOSTRA_LED;
            end
            MOSTRA_LED: begin
                liga_led        = 1'b1;
                conta_timer_led = 1'b1;
                proximo         = meio_timer_led ? APAGA_LED : MOSTRA_LED;
            end
            APAGA_LED: begin
                conta_timer_led = 1'b1;
                if (!fim_timer_led)             proximo = APAGA_LED;
                else if (saida_led_igual_nivel) proximo = INICIA_JOGADAS;
                else                            proximo = PROXIMO_LED;
            end
            PROXIMO_LED: begin
                contar_led     = 1'b1;
                zera_timer_led = 1'b1;
                proximo        = MOSTRA_LED;
            end
            INICIA_JOGADAS: begin
                zera_contador_jogada = 1'b1;
                zeraR                = 1'b1;
                zera_timeout         = 1'b1;
                proximo              = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
                conta_timeout = 1'b1;
                // a move landing with the timeout still counts as a move
                if (fez_jogada)       proximo = REGISTRA;
                else if (deu_timeout) proximo = FIM_TIMEOUT;
                else                  proximo = ESPERA_JOGADA;
`else
                proximo = fez_jogada ? REGISTRA : ESPERA_JOGADA;
`endif
            end
            REGISTRA: begin
                registraR    = 1'b1;
                zera_timeout = 1'b1;
                proximo      = COMPARACAO;
            end
            COMPARACAO: begin
                if (!jogada_igual_memoria)      proximo = FIM_ERROU;
                else if (!endereco_igual_limite) proximo = PROXIMA_JOGADA;
                else if (ultimo_nivel)          proximo = FIM_ACERTOU;
                else                            proximo = PROXIMO_NIVEL;
            end
            PROXIMA_JOGADA: begin
                conta_jogada = 1'b1;
                proximo      = ESPERA_JOGADA;
            end
            PROXIMO_NIVEL: begin
                conta_nivel          = 1'b1;
                zera_contador_jogada = 1'b1;
                proximo              = INICIA_SEQUENCIA;
            end
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                proximo = iniciar ? PREPARACAO : FIM_ACERTOU;
            end
            FIM_ERROU: begin
                pronto  = 1'b1;
                errou   = 1'b1;
                proximo = iniciar ? PREPARACAO : FIM_ERROU;
            end
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
            end
`endif
            default: proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;

endmodule

// File: tb/tb_unidade_controle_prova.sv
// Scoreboarded bench: stimulus queues expected state/mode per cycle, a negedge monitor compares.
module tb_unidade_controle_prova;
    import unidade_controle_pkg::*;

    logic clock = 1'b0;
    logic reset, iniciar, modo_dificil, sel_memoria;
    logic fez_jogada, jogada_igual_memoria, endereco_igual_limite, ultimo_nivel;
    logic saida_led_igual_nivel, meio_timer_led, fim_timer_led, deu_timeout;
    logic zera_contador_nivel, conta_nivel, zera_contador_jogada, conta_jogada, zeraR, registraR;
    logic zera_contador_led, contar_led, liga_led, zera_timer_led, conta_timer_led;
    logic zera_timeout, conta_timeout, dificuldade, memoria, pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    unidade_controle_prova dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .modo_dificil(modo_dificil),
        .sel_memoria(sel_memoria), .fez_jogada(fez_jogada),
        .jogada_igual_memoria(jogada_igual_memoria), .endereco_igual_limite(endereco_igual_limite),
        .ultimo_nivel(ultimo_nivel), .saida_led_igual_nivel(saida_led_igual_nivel),
        .meio_timer_led(meio_timer_led), .fim_timer_led(fim_timer_led), .deu_timeout(deu_timeout),
        .zera_contador_nivel(zera_contador_nivel), .conta_nivel(conta_nivel),
        .zera_contador_jogada(zera_contador_jogada), .conta_jogada(conta_jogada),
        .zeraR(zeraR), .registraR(registraR), .zera_contador_led(zera_contador_led),
        .contar_led(contar_led), .liga_led(liga_led), .zera_timer_led(zera_timer_led),
        .conta_timer_led(conta_timer_led), .zera_timeout(zera_timeout), .conta_timeout(conta_timeout),
        .dificuldade(dificuldade), .memoria(memoria), .pronto(pronto), .acertou(acertou),
        .errou(errou), .timeout(timeout), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        int         cyc;
        logic [3:0] st;
        logic [1:0] md;
        string      nm;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    logic [1:0] em;

    always @(posedge clock) cyc <= cyc + 1;

    // Expected control word per state, written straight from the state table.
    function automatic logic [16:0] esperado(input logic [3:0] s);
        logic zcn, cn, zcj, cj, zr, rr, zcl, cl, ll, ztl, ctl, zt, ct, p, a, er, t;
        {zcn, cn, zcj, cj, zr, rr, zcl, cl, ll, ztl, ctl, zt, ct, p, a, er, t} = '0;
        case (s)
            ST_PREPARACAO:       begin zcn = 1; zcj = 1; zr = 1; zt = 1; end
            ST_INICIA_SEQUENCIA: begin zcl = 1; ztl = 1; end
            ST_MOSTRA_LED:       begin ll = 1; ctl = 1; end
            ST_APAGA_LED:        ctl = 1;
            ST_PROXIMO_LED:      begin cl = 1; ztl = 1; end
            ST_INICIA_JOGADAS:   begin zcj = 1; zr = 1; zt = 1; end
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
            ST_ESPERA_JOGADA:    ct = 1;
            ST_FIM_TIMEOUT:      begin p = 1; t = 1; end
`endif
            ST_REGISTRA:         begin rr = 1; zt = 1; end
            ST_PROXIMA_JOGADA:   cj = 1;
            ST_PROXIMO_NIVEL:    begin cn = 1; zcj = 1; end
            ST_FIM_ACERTOU:      begin p = 1; a = 1; end
            ST_FIM_ERROU:        begin p = 1; er = 1; end
            default: ;
        endcase
        return {zcn, cn, zcj, cj, zr, rr, zcl, cl, ll, ztl, ctl, zt, ct, p, a, er, t};
    endfunction

    logic [16:0] ctrl;
    assign ctrl = {zera_contador_nivel, conta_nivel, zera_contador_jogada, conta_jogada, zeraR,
                   registraR, zera_contador_led, contar_led, liga_led, zera_timer_led,
                   conta_timer_led, zera_timeout, conta_timeout, pronto, acertou, errou, timeout};

    always @(negedge clock) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests = tests + 1;
            if (e.cyc != cyc || db_estado !== e.st || {dificuldade, memoria} !== e.md
                || ctrl !== esperado(e.st)) begin
                fails = fails + 1;
                $display("FAIL %s (cyc %0d/%0d): estado=%h modo=%b ctrl=%b, required estado=%h modo=%b ctrl=%b",
                         e.nm, cyc, e.cyc, db_estado, {dificuldade, memoria}, ctrl,
                         e.st, e.md, esperado(e.st));
            end
        end
    end

    // Queue what the next edge must produce, then take that edge.
    task automatic tk(input logic [3:0] st, input string nm);
        exp_t x;
        x.cyc = cyc + 1;
        x.st  = st;
        x.md  = em;
        x.nm  = nm;
        q.push_back(x);
        @(posedge clock);
        #1;
    endtask

    // LED window: on until meio, off until fim, then branch on the level match.
    task automatic led(input logic ultimo, input string nm);
        meio_timer_led = 1'b0;
        tk(ST_MOSTRA_LED, {nm, "_on_hold"});
        meio_timer_led = 1'b1;
        tk(ST_APAGA_LED, {nm, "_off"});
        meio_timer_led = 1'b0;
        fim_timer_led = 1'b0;
        tk(ST_APAGA_LED, {nm, "_off_hold"});
        fim_timer_led = 1'b1;
        saida_led_igual_nivel = ultimo;
        tk(ultimo ? ST_INICIA_JOGADAS : ST_PROXIMO_LED, {nm, "_fim"});
        fim_timer_led = 1'b0;
        saida_led_igual_nivel = 1'b0;
    endtask

    task automatic jogada(input logic igual, input logic lim, input logic ult,
                          input logic [3:0] st, input string nm);
        fez_jogada = 1'b1;
        tk(ST_REGISTRA, {nm, "_registra"});
        fez_jogada = 1'b0;
        tk(ST_COMPARACAO, {nm, "_comparacao"});
        jogada_igual_memoria = igual;
        endereco_igual_limite = lim;
        ultimo_nivel = ult;
        tk(st, {nm, "_resultado"});
        {jogada_igual_memoria, endereco_igual_limite, ultimo_nivel} = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required stimulus to complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; iniciar = 1'b0; modo_dificil = 1'b0; sel_memoria = 1'b0;
        fez_jogada = 1'b0; jogada_igual_memoria = 1'b0; endereco_igual_limite = 1'b0;
        ultimo_nivel = 1'b0; saida_led_igual_nivel = 1'b0; meio_timer_led = 1'b0;
        fim_timer_led = 1'b0; deu_timeout = 1'b0;
        em = 2'b00;

        tk(ST_INICIAL, "reset0");
        tk(ST_INICIAL, "reset1");
        reset = 1'b1;
        tk(ST_INICIAL, "idle");

        // mode latched in preparacao, visible from inicia_sequencia on
        modo_dificil = 1'b1; sel_memoria = 1'b1; iniciar = 1'b1;
        tk(ST_PREPARACAO, "start_prep");
        iniciar = 1'b0; em = 2'b11;
        tk(ST_INICIA_SEQUENCIA, "start_seq");
        tk(ST_MOSTRA_LED, "start_led");

        reset = 1'b0; em = 2'b00;
        tk(ST_INICIAL, "reset_mid_a");
        tk(ST_INICIAL, "reset_mid_b");
        reset = 1'b1;

        modo_dificil = 1'b0; sel_memoria = 1'b1; iniciar = 1'b1;
        tk(ST_PREPARACAO, "g1_prep");
        iniciar = 1'b0; em = 2'b01;
        tk(ST_INICIA_SEQUENCIA, "g1_seq");
        tk(ST_MOSTRA_LED, "g1_led");
        led(1'b1, "n0");
        tk(ST_ESPERA_JOGADA, "n0_espera");
        tk(ST_ESPERA_JOGADA, "n0_espera_hold");
        jogada(1'b1, 1'b1, 1'b0, ST_PROXIMO_NIVEL, "n0_ok");
        tk(ST_INICIA_SEQUENCIA, "n1_seq");

        // level 1: two LED windows separated by one proximo_led cycle
        tk(ST_MOSTRA_LED, "n1_led0");
        led(1'b0, "n1a");
        tk(ST_MOSTRA_LED, "n1_led1");
        led(1'b1, "n1b");
        tk(ST_ESPERA_JOGADA, "n1_espera");
        jogada(1'b1, 1'b0, 1'b0, ST_PROXIMA_JOGADA, "n1_j0");
        tk(ST_ESPERA_JOGADA, "n1_espera2");
        jogada(1'b0, 1'b1, 1'b0, ST_FIM_ERROU, "n1_erro");
        tk(ST_FIM_ERROU, "erro_hold");

        modo_dificil = 1'b1; sel_memoria = 1'b0; iniciar = 1'b1;
        tk(ST_PREPARACAO, "g2_prep");
        em = 2'b10;
        tk(ST_INICIA_SEQUENCIA, "g2_seq");
        iniciar = 1'b0;
        tk(ST_MOSTRA_LED, "g2_led");
        led(1'b1, "g2");
        tk(ST_ESPERA_JOGADA, "g2_espera");
        jogada(1'b1, 1'b1, 1'b1, ST_FIM_ACERTOU, "g2_final");
        tk(ST_FIM_ACERTOU, "acertou_hold");

        // iniciar held through fim_acertou: immediate restart
        iniciar = 1'b1;
        tk(ST_PREPARACAO, "g3_prep");
        tk(ST_INICIA_SEQUENCIA, "g3_seq");
        iniciar = 1'b0;
        tk(ST_MOSTRA_LED, "g3_led");
        led(1'b1, "g3");
        tk(ST_ESPERA_JOGADA, "g3_espera");
        deu_timeout = 1'b1; fez_jogada = 1'b1;
        tk(ST_REGISTRA, "g3_move_beats_timeout");
        deu_timeout = 1'b0; fez_jogada = 1'b0;
        tk(ST_COMPARACAO, "g3_comparacao");
        jogada_igual_memoria = 1'b1;
        tk(ST_PROXIMA_JOGADA, "g3_proxima");
        jogada_igual_memoria = 1'b0;
        tk(ST_ESPERA_JOGADA, "g3_espera2");
        deu_timeout = 1'b1;
`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
        tk(ST_FIM_TIMEOUT, "g3_timeout");
        deu_timeout = 1'b0;
        tk(ST_FIM_TIMEOUT, "timeout_hold");
        iniciar = 1'b1;
        tk(ST_PREPARACAO, "g4_prep");
        iniciar = 1'b0;
`else
        tk(ST_ESPERA_JOGADA, "g3_timeout_ignored");
        deu_timeout = 1'b0;
        tk(ST_ESPERA_JOGADA, "g3_espera_hold");
`endif

        repeat (2) @(negedge clock);
        if (q.size() != 0) begin
            fails = fails + 1;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
